bitbakery_frame_sequencer: RTL
==============================

Name: bitbakery_frame_sequencer

Overview:
- Packetiser between the BitBakery game core and the byte-level UART transmitter. It runs on the 50 MHz clock.
- Snapshots the status bytes D0/D1/D2 and the 512-bit obstacle and objective maps at the start of each frame.
- Streams the snapshot as a fixed 131-byte frame, one byte per UART handshake.
- Waits a programmable idle gap, then starts the next frame.

Parameters:
- GAP_M, 500000: idle clock cycles between the end of one frame and the next capture (10 ms at 50 MHz).
- GAP_N, 20: width of the gap counter.
- TIMEOUT_M, 100000: maximum cycles to wait for tx_pronto after a tx_partida; exceeding it aborts the frame.
- TIMEOUT_N, 17: width of the timeout counter.

Ports:
- clock, input, 1: system clock (50 MHz, undivided).
- reset, input, 1: asynchronous, active-high.
- habilita, input, 1: allows frames to start; sampled only in OCIOSO.
- D0, input, 8: status byte {2'b00, minigame, estado}.
- D1, input, 8: status byte {2'b01, jogada}.
- D2, input, 8: status byte {2'b10, 0, dificuldade, player_position}.
- map_obstacles, input, 512: obstacle bitmap.
- map_objectives, input, 512: objective bitmap.
- tx_pronto, input, 1: one-cycle pulse from the UART meaning the current byte is fully sent.
- tx_dados, output, 8: byte to transmit.
- tx_partida, output, 1: one-cycle start pulse to the UART.
- quadro_ativo, output, 1: high from CAPTURA through the last byte's tx_pronto.
- fim_quadro, output, 1: one-cycle pulse when a frame completes normally.
- erro_timeout, output, 1: sticky flag; set on abort, cleared by the next CAPTURA.
- db_indice, output, 8: current byte index 0..130.
- db_estado, output, 3: FSM state code.

Behaviour:
- Reset (async): state OCIOSO. All of these are 0: tx_dados, tx_partida, quadro_ativo, fim_quadro, erro_timeout, db_indice, both counters. Snapshot registers are cleared.
- State codes: OCIOSO=0, CAPTURA=1, ENVIA=2, ESPERA=3, PROXIMO=4, INTERVALO=5. Codes 6 and 7 go to OCIOSO on the next cycle.
- OCIOSO: if habilita=1, go to CAPTURA; otherwise stay.
- CAPTURA (1 cycle):
  - Latch D0, D1, D2, map_obstacles, map_objectives into snapshot registers.
  - Set index=0, clear erro_timeout, go to ENVIA.
  - Input changes after this cycle do not affect the frame in flight.
- Byte map by index k:
  - k=0: D0; k=1: D1; k=2: D2.
  - k=3..66: obstacles[8*(k-3)+7 : 8*(k-3)].
  - k=67..130: objectives[8*(k-67)+7 : 8*(k-67)].
  - The LSB byte of each map is sent first.
- ENVIA (1 cycle): tx_dados <= byte(k); tx_partida=1 for exactly this cycle; timeout counter cleared; go to ESPERA.
- tx_dados is registered and holds its value from ENVIA until the next ENVIA; it never changes while in ESPERA.
- ESPERA:
  - tx_pronto=1: go to PROXIMO.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_M-1 without tx_pronto: set erro_timeout, drop quadro_ativo, skip fim_quadro, go to INTERVALO.
  - If tx_pronto arrives in the same cycle the counter reaches TIMEOUT_M-1, tx_pronto wins (no abort).
- A tx_pronto seen in any state other than ESPERA is ignored.
- PROXIMO:
  - k=130: pulse fim_quadro, drop quadro_ativo, go to INTERVALO.
  - Otherwise k<=k+1 and go to ENVIA.
  - Per-byte overhead beyond the UART time is 3 cycles (ENVIA, ESPERA entry, PROXIMO).
- INTERVALO:
  - The gap counter counts up from 0. At GAP_M-1 it clears and the FSM goes to OCIOSO.
  - If habilita=1 there, the next CAPTURA follows one cycle later.
- habilita is ignored outside OCIOSO. Dropping it mid-frame does not stop the current frame.
- Reset mid-frame: immediate return to OCIOSO with all outputs 0. No partial byte is re-issued.
- The index counter is 8 bits and never exceeds 130. There is no wrap-around; counters saturate at the cleared state.

Test Plan:
- Reset, then habilita=1; D0=0x27, D1=0x45, D2=0x9A, obstacles=0, objectives=0. Model a UART giving tx_pronto 10 cycles after each tx_partida. Required: exactly 131 tx_partida pulses with bytes 0x27, 0x45, 0x9A, then 128×0x00; one fim_quadro; erro_timeout=0.
- obstacles[7:0]=0xA5, obstacles[511:504]=0x3C, objectives[15:8]=0x81. Required: byte 3=0xA5, byte 66=0x3C, byte 68=0x81, all other map bytes 0x00.
- Change D0 from 0x27 to 0x11 while byte 5 is in ESPERA. Required: the rest of the frame is unchanged; the next frame's byte 0 is 0x11.
- Never assert tx_pronto, with TIMEOUT_M=16. Required: one tx_partida, then erro_timeout=1 in ESPERA's 16th cycle; no fim_quadro; the gap runs; the next frame's CAPTURA clears erro_timeout.
- Assert reset asynchronously while index=40. Required: all outputs 0 immediately, state 0. After release with habilita=1, a new frame starts at index 0.
- GAP_M=8 with habilita held high. Required: fim_quadro, then 8 cycles in INTERVALO, 1 in OCIOSO, then CAPTURA. Stray tx_pronto pulses during INTERVALO cause no tx_partida.

Source files
------------

// File: rtl/bitbakery_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : bitbakery_frame_sequencer
//  Purpose  : Packetiser between the BitBakery game core and a byte-level
//             UART transmitter. At the start of each frame it snapshots the
//             three status bytes and both 512-bit maps, then streams them as
//             a fixed 131-byte frame (one byte per UART handshake), waits a
//             programmable idle gap and starts over.
//  Ports    : clock, reset            - clock, async active-high reset
//             habilita                - allow a new frame (seen in OCIOSO)
//             D0, D1, D2              - status bytes (frame bytes 0..2)
//             map_obstacles           - obstacle bitmap (frame bytes 3..66)
//             map_objectives          - objective bitmap (frame bytes 67..130)
//             tx_pronto               - UART "byte sent" pulse
//             tx_dados, tx_partida    - byte to send and its start pulse
//             quadro_ativo            - frame in progress
//             fim_quadro              - frame completed normally (pulse)
//             erro_timeout            - sticky abort flag
//             db_indice, db_estado    - debug: byte index and state code
//  Revision : 1.0 - initial release
// ============================================================================
module bitbakery_frame_sequencer #(
    parameter int GAP_M     = 500000,
    parameter int GAP_N     = 20,
    parameter int TIMEOUT_M = 100000,
    parameter int TIMEOUT_N = 17
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         habilita,
    input  logic [7:0]   D0,
    input  logic [7:0]   D1,
    input  logic [7:0]   D2,
    input  logic [511:0] map_obstacles,
    input  logic [511:0] map_objectives,
    input  logic         tx_pronto,
    output logic [7:0]   tx_dados,
    output logic         tx_partida,
    output logic         quadro_ativo,
    output logic         fim_quadro,
    output logic         erro_timeout,
    output logic [7:0]   db_indice,
    output logic [2:0]   db_estado
);

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        CAPTURA   = 3'd1,
        ENVIA     = 3'd2,
        ESPERA    = 3'd3,
        PROXIMO   = 3'd4,
        INTERVALO = 3'd5
    } state_t;

    localparam logic [7:0]           LAST_INDEX   = 8'd130;
    localparam logic [TIMEOUT_N-1:0] TIMEOUT_LAST = TIMEOUT_N'(TIMEOUT_M - 1);
    localparam logic [GAP_N-1:0]     GAP_LAST     = GAP_N'(GAP_M - 1);

    state_t                 state;
    state_t                 state_next;
    logic [7:0]             index;
    logic [7:0]             index_next;
    logic [TIMEOUT_N-1:0]   timeout_cnt;
    logic [GAP_N-1:0]       gap_cnt;
    logic                   timeout_hit;
    logic                   gap_done;
    logic                   last_byte;

    // Snapshot laid out so that frame byte k sits at bits [8k+7:8k]:
    // {objectives, obstacles, D2, D1, D0}. Map bytes therefore go out
    // LSB byte first without any further reordering.
    logic [1047:0]          snapshot;
    logic [7:0]             byte_next;

    assign index_next  = index + 8'd1;
    assign byte_next   = snapshot[{index_next, 3'b000} +: 8];
    assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);
    assign gap_done    = (gap_cnt == GAP_LAST);
    assign last_byte   = (index == LAST_INDEX);

    assign db_indice   = index;
    assign db_estado   = state;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= OCIOSO;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore/Mealy control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = OCIOSO;
        tx_partida   = 1'b0;
        quadro_ativo = 1'b0;
        fim_quadro   = 1'b0;
        case (state)
            OCIOSO: begin
                state_next = habilita ? CAPTURA : OCIOSO;
            end
            CAPTURA: begin
                quadro_ativo = 1'b1;
                state_next   = ENVIA;
            end
            ENVIA: begin
                quadro_ativo = 1'b1;
                tx_partida   = 1'b1;
                state_next   = ESPERA;
            end
            ESPERA: begin
                quadro_ativo = 1'b1;
                // A completion arriving on the last allowed cycle still
                // counts as a success, so tx_pronto is tested first.
                if (tx_pronto) begin
                    state_next = PROXIMO;
                end else if (timeout_hit) begin
                    state_next = INTERVALO;
                end else begin
                    state_next = ESPERA;
                end
            end
            PROXIMO: begin
                if (last_byte) begin
                    fim_quadro = 1'b1;
                    state_next = INTERVALO;
                end else begin
                    quadro_ativo = 1'b1;
                    state_next   = ENVIA;
                end
            end
            INTERVALO: begin
                state_next = gap_done ? OCIOSO : INTERVALO;
            end
            default: begin
                // Unused codes recover to idle.
                state_next = OCIOSO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: snapshot, byte index, outgoing byte, counters, error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snapshot     <= '0;
            index        <= '0;
            tx_dados     <= '0;
            timeout_cnt  <= '0;
            gap_cnt      <= '0;
            erro_timeout <= 1'b0;
        end else begin
            case (state)
                CAPTURA: begin
                    snapshot     <= {map_objectives, map_obstacles, D2, D1, D0};
                    index        <= '0;
                    erro_timeout <= 1'b0;
                    // tx_dados is loaded one cycle ahead of ENVIA so the
                    // byte is already stable while tx_partida is high.
                    // Byte 0 comes straight from D0, the same value being
                    // latched into the snapshot on this edge.
                    tx_dados     <= D0;
                end
                ENVIA: begin
                    timeout_cnt <= '0;
                end
                ESPERA: begin
                    if (tx_pronto) begin
                        timeout_cnt <= '0;
                    end else if (timeout_hit) begin
                        timeout_cnt  <= '0;
                        erro_timeout <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                PROXIMO: begin
                    // The index stops at the last byte; it is only
                    // rewound by the next capture.
                    if (!last_byte) begin
                        index    <= index_next;
                        tx_dados <= byte_next;
                    end
                end
                INTERVALO: begin
                    if (gap_done) begin
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
